// File: rtl/simd_mem_controller.sv
`default_nettype none
// ============================================================================
// Module   : simd_mem_controller
// Purpose  : Sole owner of the SIMD unit's shared single-port data memory.
//            Arbitrates between the DMA write path and NUM_PU processing-unit
//            read requesters and issues one memory access at a time. The DMA
//            has fixed priority, but after DMA_BURST_MAX back-to-back DMA
//            grants with a PU waiting, one PU read is let through. PUs are
//            served round-robin.
// Ports    : clk, reset              - clock, synchronous active-high reset
//            dma_req/addr/wdata/ack  - DMA write request channel
//            pu_req/addr/gnt         - per-PU read request channel
//            pu_rvalid/pu_rdata      - read return (shared data bus)
//            mem_en/we/addr/wdata    - memory command
//            mem_rdata               - memory read data (1-cycle latency)
//            busy                    - controller not in IDLE
// Revision : 1.0 - initial release
// ============================================================================
module simd_mem_controller #(
    parameter int NUM_PU        = 4,
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 32,
    parameter int DMA_BURST_MAX = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dma_req,
    input  logic [ADDR_W-1:0]        dma_addr,
    input  logic [DATA_W-1:0]        dma_wdata,
    output logic                     dma_ack,
    input  logic [NUM_PU-1:0]        pu_req,
    input  logic [NUM_PU*ADDR_W-1:0] pu_addr,
    output logic [NUM_PU-1:0]        pu_gnt,
    output logic [NUM_PU-1:0]        pu_rvalid,
    output logic [DATA_W-1:0]        pu_rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     busy
);

    localparam int c_PTR_W = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;
    localparam int c_CNT_W = $clog2(DMA_BURST_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(DMA_BURST_MAX);
    localparam logic [c_PTR_W-1:0] c_PTR_INIT  = c_PTR_W'(NUM_PU - 1);
    localparam logic [c_PTR_W:0]   c_NUM_PU_WX = (c_PTR_W + 1)'(NUM_PU);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_WRITE = 2'd1;
    localparam logic [1:0] c_S_READ  = 2'd2;
    localparam logic [1:0] c_S_RDATA = 2'd3;

    logic [1:0]         r_state;
    logic [c_PTR_W-1:0] r_rr_ptr;
    logic [c_CNT_W-1:0] r_dma_cnt;
    logic [c_PTR_W-1:0] r_sel_idx;
    logic [NUM_PU-1:0]  r_sel_oh;

    logic               w_pick_vld;
    logic [c_PTR_W:0]   w_shift;
    logic [NUM_PU-1:0]  w_rot;
    logic [c_PTR_W:0]   w_sum;
    logic [c_PTR_W-1:0] w_pick_idx;
    logic [NUM_PU-1:0]  w_pick_oh;
    logic [ADDR_W-1:0]  w_pick_addr;

    // Round-robin pick. The request vector is rotated so that bit m of w_rot
    // belongs to PU (rr_ptr + 1 + m) mod NUM_PU; the lowest set bit is the
    // winner. The index is rebuilt in one extra bit so non-power-of-two
    // NUM_PU wraps correctly.
    always_comb begin
        w_pick_vld  = |pu_req;
        w_shift     = {1'b0, r_rr_ptr} + (c_PTR_W + 1)'(1);
        w_rot       = NUM_PU'({pu_req, pu_req} >> w_shift);
        w_sum       = '0;
        w_pick_idx  = '0;
        w_pick_oh   = '0;
        w_pick_addr = '0;
        for (int m = NUM_PU - 1; m >= 0; m--) begin
            if (w_rot[m]) begin
                w_sum = {1'b0, r_rr_ptr} + (c_PTR_W + 1)'(m + 1);
            end
        end
        if (w_sum >= c_NUM_PU_WX) begin
            w_sum = w_sum - c_NUM_PU_WX;
        end
        w_pick_idx = w_sum[c_PTR_W-1:0];
        for (int i = 0; i < NUM_PU; i++) begin
            if (w_pick_idx == c_PTR_W'(i)) begin
                w_pick_oh[i] = w_pick_vld;
                w_pick_addr  = pu_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Every output is loaded on the edge that enters the state it belongs
    // to, so all outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_S_IDLE;
            r_rr_ptr  <= c_PTR_INIT;
            r_dma_cnt <= '0;
            r_sel_idx <= '0;
            r_sel_oh  <= '0;
            dma_ack   <= 1'b0;
            pu_gnt    <= '0;
            pu_rvalid <= '0;
            pu_rdata  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            // Handshake outputs are single-cycle pulses.
            dma_ack   <= 1'b0;
            pu_gnt    <= '0;
            pu_rvalid <= '0;
            case (r_state)
                c_S_IDLE: begin
                    // Burst count only matters while some PU is waiting.
                    if (!w_pick_vld) begin
                        r_dma_cnt <= '0;
                    end
                    if (dma_req && (!w_pick_vld || (r_dma_cnt < c_CNT_MAX))) begin
                        r_state   <= c_S_WRITE;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= dma_addr;
                        mem_wdata <= dma_wdata;
                        dma_ack   <= 1'b1;
                        busy      <= 1'b1;
                    end else if (w_pick_vld) begin
                        r_state   <= c_S_READ;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= w_pick_addr;
                        pu_gnt    <= w_pick_oh;
                        r_sel_idx <= w_pick_idx;
                        r_sel_oh  <= w_pick_oh;
                        r_dma_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end
                c_S_WRITE: begin
                    r_state <= c_S_IDLE;
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    busy    <= 1'b0;
                    if (r_dma_cnt != c_CNT_MAX) begin
                        r_dma_cnt <= r_dma_cnt + c_CNT_W'(1);
                    end
                end
                c_S_READ: begin
                    r_state  <= c_S_RDATA;
                    mem_en   <= 1'b0;
                    r_rr_ptr <= r_sel_idx;
                end
                c_S_RDATA: begin
                    // Memory data is valid during this cycle; present it in
                    // the following IDLE cycle without stalling arbitration.
                    r_state   <= c_S_IDLE;
                    pu_rdata  <= mem_rdata;
                    pu_rvalid <= r_sel_oh;
                    busy      <= 1'b0;
                end
                default: begin
                    r_state <= c_S_IDLE;
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_simd_mem_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_simd_mem_controller
// Purpose  : Directed self-checking bench for simd_mem_controller with a
//            behavioural single-port memory (1-cycle read latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_simd_mem_controller;

    localparam int NUM_PU = 4;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     dma_req = 1'b0;
    logic [ADDR_W-1:0]        dma_addr = '0;
    logic [DATA_W-1:0]        dma_wdata = '0;
    logic                     dma_ack;
    logic [NUM_PU-1:0]        pu_req = '0;
    logic [NUM_PU*ADDR_W-1:0] pu_addr = '0;
    logic [NUM_PU-1:0]        pu_gnt;
    logic [NUM_PU-1:0]        pu_rvalid;
    logic [DATA_W-1:0]        pu_rdata;
    logic                     mem_en;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic [DATA_W-1:0]        mem_rdata = '0;
    logic                     busy;

    logic [DATA_W-1:0]        mem [0:255];

    int total = 0;
    int bad   = 0;

    simd_mem_controller #(
        .NUM_PU       (NUM_PU),
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .DMA_BURST_MAX(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .dma_req  (dma_req),
        .dma_addr (dma_addr),
        .dma_wdata(dma_wdata),
        .dma_ack  (dma_ack),
        .pu_req   (pu_req),
        .pu_addr  (pu_addr),
        .pu_gnt   (pu_gnt),
        .pu_rvalid(pu_rvalid),
        .pu_rdata (pu_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Read data is only meaningful in the cycle after a read; otherwise a
    // poison value is driven so a mistimed capture shows up.
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
        else                   mem_rdata <= 32'hDEADBEEF;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        dma_req = 1'b0;
        pu_req  = '0;
        tick();
        reset   = 1'b0;
    endtask

    logic [NUM_PU-1:0] exp_g;
    logic [NUM_PU-1:0] exp_v;
    logic              exp_a;
    int                nack;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int i = 0; i < NUM_PU; i++) mem[8'h30 + i] = 32'hA0 + i;

        // ---- 1: reset values, then a single DMA write
        tick();
        tick();
        chk("rst busy",   busy,      0);
        chk("rst mem_en", mem_en,    0);
        chk("rst ack",    dma_ack,   0);
        chk("rst gnt",    pu_gnt,    0);
        chk("rst rvalid", pu_rvalid, 0);
        chk("rst rdata",  pu_rdata,  0);
        chk("rst addr",   mem_addr,  0);
        reset = 1'b0;
        tick();
        dma_req   = 1'b1;
        dma_addr  = 8'h10;
        dma_wdata = 32'hCAFEF00D;
        tick();
        chk("t1 mem_en", mem_en,    1);
        chk("t1 mem_we", mem_we,    1);
        chk("t1 addr",   mem_addr,  8'h10);
        chk("t1 wdata",  mem_wdata, 32'hCAFEF00D);
        chk("t1 ack",    dma_ack,   1);
        chk("t1 busy",   busy,      1);
        dma_req = 1'b0;
        tick();
        chk("t1 ack off",  dma_ack, 0);
        chk("t1 busy off", busy,    0);
        chk("t1 en off",   mem_en,  0);
        chk("t1 mem",      mem[8'h10], 32'hCAFEF00D);

        // ---- 2: single PU2 read
        mem[8'h22] = 32'h12345678;
        pu_addr[2*ADDR_W +: ADDR_W] = 8'h22;
        pu_req = 4'b0100;
        tick();
        chk("t2 gnt",    pu_gnt,   4'b0100);
        chk("t2 mem_en", mem_en,   1);
        chk("t2 mem_we", mem_we,   0);
        chk("t2 addr",   mem_addr, 8'h22);
        pu_req = '0;
        tick();
        chk("t2 gnt off", pu_gnt,    0);
        chk("t2 rv early", pu_rvalid, 0);
        chk("t2 busy",    busy,      1);
        tick();
        chk("t2 rvalid", pu_rvalid, 4'b0100);
        chk("t2 rdata",  pu_rdata,  32'h12345678);
        chk("t2 idle",   busy,      0);
        tick();
        chk("t2 rv off", pu_rvalid, 0);

        // ---- 3: all PUs held, round-robin with wrap
        do_reset();
        for (int i = 0; i < NUM_PU; i++) pu_addr[i*ADDR_W +: ADDR_W] = 8'(8'h30 + i);
        pu_req = 4'b1111;
        for (int c = 1; c <= 14; c++) begin
            tick();
            exp_g = ((c - 1) % 3 == 0) ? (4'b0001 << (((c - 1) / 3) % 4)) : 4'b0000;
            chk("t3 gnt", pu_gnt, exp_g);
            if (c >= 3 && (c - 3) % 3 == 0) begin
                exp_v = 4'b0001 << (((c - 3) / 3) % 4);
                chk("t3 rvalid", pu_rvalid, exp_v);
                chk("t3 rdata",  pu_rdata,  32'hA0 + ((c - 3) / 3) % 4);
            end else begin
                chk("t3 rvalid idle", pu_rvalid, 0);
            end
        end
        pu_req = '0;
        repeat (3) tick();

        // ---- 4: DMA burst limit against a waiting PU1
        do_reset();
        nack      = 0;
        dma_req   = 1'b1;
        dma_addr  = 8'h40;
        dma_wdata = 32'h1000;
        pu_addr[1*ADDR_W +: ADDR_W] = 8'h50;
        pu_req    = 4'b0010;
        for (int c = 1; c <= 20; c++) begin
            tick();
            exp_a = ((c <= 7) && (c % 2 == 1)) || ((c >= 12) && (c <= 18) && (c % 2 == 0));
            exp_g = (c == 9 || c == 20) ? 4'b0010 : 4'b0000;
            chk("t4 ack", dma_ack, exp_a);
            chk("t4 gnt", pu_gnt,  exp_g);
            if (dma_ack) begin
                chk("t4 wdata", mem_wdata, 32'(32'h1000 + nack));
                nack++;
                dma_addr  = 8'(8'h40 + nack);
                dma_wdata = 32'(32'h1000 + nack);
            end
        end
        chk("t4 ack count", nack, 8);
        dma_req = 1'b0;
        pu_req  = '0;
        repeat (3) tick();

        // ---- 5: reset during RDATA of a PU3 read
        do_reset();
        pu_addr[3*ADDR_W +: ADDR_W] = 8'h33;
        mem[8'h33] = 32'h55AA;
        pu_req = 4'b1000;
        tick();
        chk("t5 gnt3", pu_gnt, 4'b1000);
        pu_req = '0;
        tick();
        reset = 1'b1;
        tick();
        chk("t5 rvalid", pu_rvalid, 0);
        chk("t5 rdata",  pu_rdata,  0);
        chk("t5 busy",   busy,      0);
        chk("t5 mem_en", mem_en,    0);
        chk("t5 gnt",    pu_gnt,    0);
        reset = 1'b0;
        pu_addr[0 +: ADDR_W] = 8'h30;
        pu_req = 4'b1001;
        tick();
        chk("t5 gnt0", pu_gnt, 4'b0001);
        pu_req = 4'b1000;
        tick();
        tick();
        chk("t5 rvalid0", pu_rvalid, 4'b0001);
        chk("t5 rdata0",  pu_rdata,  32'hA0);
        tick();
        chk("t5 gnt3 next", pu_gnt, 4'b1000);
        pu_req = '0;
        repeat (3) tick();

        // ---- 6: simultaneous DMA and PU0 with empty burst count
        do_reset();
        dma_req   = 1'b1;
        dma_addr  = 8'h60;
        dma_wdata = 32'h6666;
        pu_req    = 4'b0001;
        tick();
        chk("t6 ack", dma_ack, 1);
        chk("t6 no gnt", pu_gnt, 0);
        dma_req = 1'b0;
        tick();
        chk("t6 ack off", dma_ack, 0);
        chk("t6 idle gnt", pu_gnt, 0);
        chk("t6 idle busy", busy, 0);
        tick();
        chk("t6 gnt0", pu_gnt, 4'b0001);
        pu_req = '0;
        tick();
        tick();
        chk("t6 rvalid", pu_rvalid, 4'b0001);
        chk("t6 rdata",  pu_rdata,  32'hA0);
        chk("t6 mem",    mem[8'h60], 32'h6666);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
